// File: rtl/vector_exec_unit_if.sv
// Request/response bundle between the decode stage and the vector execution unit.
// master = issuing side, slave = vector_exec_unit.
interface vector_exec_unit_if #(
    parameter int ELEN  = 32,
    parameter int VLMAX = 8
);
    localparam int VLW = $clog2(VLMAX) + 1;

    logic                     req_valid;
    logic                     req_ready;
    logic [2:0]               req_op;
    logic                     req_use_scalar;
    logic [ELEN-1:0]          req_scalar;
    logic [VLW-1:0]           req_vl;
    logic [VLMAX*ELEN-1:0]    req_vs1;
    logic [VLMAX*ELEN-1:0]    req_vs2;
    logic [VLMAX*ELEN-1:0]    req_vd;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [VLMAX*ELEN-1:0]    rsp_vd;
    logic                     rsp_illegal;

    modport master (
        output req_valid, req_op, req_use_scalar, req_scalar, req_vl,
               req_vs1, req_vs2, req_vd, rsp_ready,
        input  req_ready, rsp_valid, rsp_vd, rsp_illegal
    );

    modport slave (
        input  req_valid, req_op, req_use_scalar, req_scalar, req_vl,
               req_vs1, req_vs2, req_vd, rsp_ready,
        output req_ready, rsp_valid, rsp_vd, rsp_illegal
    );
endinterface

// File: rtl/vector_exec_unit.sv
// Multi-cycle vector ALU: LANES elements per beat, vl tail-undisturbed.
// Define VEXEC_MACC_EN to build the MACC multipliers; otherwise op 100 is illegal.
module vector_exec_unit #(
    parameter int ELEN  = 32,
    parameter int VLMAX = 8,
    parameter int LANES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    vector_exec_unit_if.slave    bus,
    output logic                 busy
);
    localparam int VLW   = $clog2(VLMAX) + 1;
    localparam int IW    = (VLMAX > 1) ? $clog2(VLMAX) : 1;
    localparam int BEATS = VLMAX / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_SLUP   = 3'd2;
    localparam logic [2:0] OP_SLDOWN = 3'd3;
    localparam logic [2:0] OP_MACC   = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t          state_reg, state_next;
    logic            rsp_valid_reg, rsp_valid_next;
    logic [BW-1:0]   beat_reg;
    logic [2:0]      op_reg;
    logic            use_scalar_reg;
    logic [ELEN-1:0] scalar_reg;
    logic [VLW-1:0]  vl_reg;
    logic            illegal_reg;
    logic [ELEN-1:0] vs1_reg    [VLMAX];
    logic [ELEN-1:0] vs2_reg    [VLMAX];
    logic [ELEN-1:0] vd_old_reg [VLMAX];
    logic [ELEN-1:0] result_reg [VLMAX];

    logic            accept;
    logic            req_illegal;
    logic            last_beat;
    logic [VLW-1:0]  req_vl_eff;
    logic [IW-1:0]   lane_idx [LANES];
    logic [ELEN-1:0] lane_val [LANES];

    assign accept     = (state_reg == IDLE) && bus.req_valid;
    assign req_vl_eff = (bus.req_vl > VLW'(VLMAX)) ? VLW'(VLMAX) : bus.req_vl;
    assign last_beat  = (beat_reg == BW'(BEATS - 1));
`ifdef VEXEC_MACC_EN
    assign req_illegal = (bus.req_op > OP_MACC);
`else
    assign req_illegal = (bus.req_op >= OP_MACC);
`endif

    // Short-path responses (illegal or vl=0) spend one settle cycle in DONE
    // before rsp_valid rises, giving them a one-cycle latency.
    always_comb begin
        state_next     = state_reg;
        rsp_valid_next = rsp_valid_reg;
        case (state_reg)
            IDLE: if (bus.req_valid)
                      state_next = (req_illegal || req_vl_eff == '0) ? DONE : EXEC;
            EXEC: if (last_beat) begin
                      state_next     = DONE;
                      rsp_valid_next = 1'b1;
                  end
            DONE: if (!rsp_valid_reg) begin
                      rsp_valid_next = 1'b1;
                  end else if (bus.rsp_ready) begin
                      state_next     = IDLE;
                      rsp_valid_next = 1'b0;
                  end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_idx
        assign lane_idx[gi] = IW'(beat_reg * LANES + gi);
    end

    always_comb begin
        logic [ELEN-1:0] a;
        logic [VLW-1:0]  pos;
        a   = '0;
        pos = '0;
        for (int l = 0; l < LANES; l++) begin
            a   = use_scalar_reg ? scalar_reg : vs1_reg[lane_idx[l]];
            pos = VLW'(lane_idx[l]);
            lane_val[l] = vd_old_reg[lane_idx[l]];
            if (pos < vl_reg) begin
                case (op_reg)
                    OP_ADD:    lane_val[l] = vs2_reg[lane_idx[l]] + a;
                    OP_SUB:    lane_val[l] = vs2_reg[lane_idx[l]] - a;
                    OP_SLUP:   lane_val[l] = (lane_idx[l] == '0) ? scalar_reg
                                           : vs2_reg[IW'(lane_idx[l] - 1'b1)];
                    OP_SLDOWN: lane_val[l] = (pos + 1'b1 == vl_reg) ? scalar_reg
                                           : vs2_reg[IW'(lane_idx[l] + 1'b1)];
`ifdef VEXEC_MACC_EN
                    OP_MACC:   lane_val[l] = vd_old_reg[lane_idx[l]] + a * vs2_reg[lane_idx[l]];
`endif
                    default:   lane_val[l] = vd_old_reg[lane_idx[l]];
                endcase
            end
        end
    end

    // The result register is preloaded with the old destination so that
    // short-path responses and untouched tails already hold req_vd.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            beat_reg    <= '0;
            illegal_reg <= 1'b0;
            for (int i = 0; i < VLMAX; i++) result_reg[i] <= '0;
        end else if (accept) begin
            beat_reg       <= '0;
            illegal_reg    <= req_illegal;
            op_reg         <= bus.req_op;
            use_scalar_reg <= bus.req_use_scalar;
            scalar_reg     <= bus.req_scalar;
            vl_reg         <= req_vl_eff;
            for (int i = 0; i < VLMAX; i++) begin
                vs1_reg[i]    <= bus.req_vs1[i*ELEN +: ELEN];
                vs2_reg[i]    <= bus.req_vs2[i*ELEN +: ELEN];
                vd_old_reg[i] <= bus.req_vd[i*ELEN +: ELEN];
                result_reg[i] <= bus.req_vd[i*ELEN +: ELEN];
            end
        end else if (state_reg == EXEC) begin
            for (int l = 0; l < LANES; l++) result_reg[lane_idx[l]] <= lane_val[l];
            beat_reg <= beat_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < VLMAX; gi++) begin : g_rsp_pack
        assign bus.rsp_vd[gi*ELEN +: ELEN] = result_reg[gi];
    end

    assign bus.req_ready   = (state_reg == IDLE);
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_illegal = illegal_reg;
    assign busy            = (state_reg != IDLE);
endmodule

// File: tb/tb_vector_exec_unit.sv
// Self-checking bench for vector_exec_unit: directed cases plus randomized
// ops compared against an element-by-element reference model.
module tb_vector_exec_unit;
    localparam int ELEN  = 32;
    localparam int VLMAX = 8;
    localparam int LANES = 2;
    localparam int W     = VLMAX * ELEN;
    localparam int VLW   = $clog2(VLMAX) + 1;
    localparam int BEATS = VLMAX / LANES;

    logic clk;
    logic resetn;
    logic busy;
    int   pass_cnt;
    int   check_cnt;

    vector_exec_unit_if #(.ELEN(ELEN), .VLMAX(VLMAX)) bus ();

    vector_exec_unit #(.ELEN(ELEN), .VLMAX(VLMAX), .LANES(LANES)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < VLMAX; i++) v[i*ELEN +: ELEN] = $urandom;
        return v;
    endfunction

    // Reference: apply the operation rules element by element.
    function automatic void ref_model(input logic [2:0] op, input logic us,
                                      input logic [ELEN-1:0] sc, input logic [VLW-1:0] vl,
                                      input logic [W-1:0] vs1, input logic [W-1:0] vs2,
                                      input logic [W-1:0] vd, output logic [W-1:0] res,
                                      output logic ill, output int lat);
        int n;
        logic [ELEN-1:0] a, b;
        logic [63:0] p;
        n   = (int'(vl) > VLMAX) ? VLMAX : int'(vl);
        ill = (op > 3'd4);
`ifndef VEXEC_MACC_EN
        if (op == 3'd4) ill = 1'b1;
`endif
        res = vd;
        if (!ill) begin
            for (int i = 0; i < n; i++) begin
                a = us ? sc : vs1[i*ELEN +: ELEN];
                b = vs2[i*ELEN +: ELEN];
                case (op)
                    3'd0: res[i*ELEN +: ELEN] = b + a;
                    3'd1: res[i*ELEN +: ELEN] = b - a;
                    3'd2: res[i*ELEN +: ELEN] = (i == 0) ? sc : vs2[(i-1)*ELEN +: ELEN];
                    3'd3: res[i*ELEN +: ELEN] = (i == n-1) ? sc : vs2[(i+1)*ELEN +: ELEN];
                    default: begin
                        p = {32'd0, a} * {32'd0, b};
                        res[i*ELEN +: ELEN] = vd[i*ELEN +: ELEN] + p[31:0];
                    end
                endcase
            end
        end
        lat = (ill || n == 0) ? 1 : BEATS;
    endfunction

    // Issue one request and wait (bounded) for the response; leaves rsp pending.
    task automatic do_op(input logic [2:0] op, input logic us, input logic [ELEN-1:0] sc,
                         input logic [VLW-1:0] vl, input logic [W-1:0] vs1,
                         input logic [W-1:0] vs2, input logic [W-1:0] vd,
                         output int lat, output logic [W-1:0] got_vd, output logic got_ill);
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        bus.req_op = op; bus.req_use_scalar = us; bus.req_scalar = sc; bus.req_vl = vl;
        bus.req_vs1 = vs1; bus.req_vs2 = vs2; bus.req_vd = vd;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_op = 3'($urandom); bus.req_use_scalar = 1'($urandom);
        bus.req_scalar = $urandom; bus.req_vl = VLW'($urandom);
        bus.req_vs1 = rand_vec(); bus.req_vs2 = rand_vec(); bus.req_vd = rand_vec();
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.rsp_valid) lat = -1;
        got_vd  = bus.rsp_vd;
        got_ill = bus.rsp_illegal;
        $display("op=%0d us=%0b vl=%0d scalar=%h lat=%0d illegal=%0b vd=%h",
                 op, us, vl, sc, lat, got_ill, got_vd);
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_vl = VLW'(8);
        repeat (3) @(posedge clk);
        #1;
        check_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); else pass_cnt++;
        check_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); else pass_cnt++;
        check_cnt++; if (bus.rsp_vd !== '0) $display("FAIL reset_rsp_vd got=%h exp=0", bus.rsp_vd); else pass_cnt++;
        check_cnt++; if (bus.rsp_illegal !== 1'b0) $display("FAIL reset_rsp_illegal got=%b exp=0", bus.rsp_illegal); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        bus.req_valid = 1'b0;
        resetn = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_add();
        logic [W-1:0] vs1, vs2, vd, exp, got;
        logic ill; int lat;
        for (int i = 0; i < VLMAX; i++) begin
            vs1[i*ELEN +: ELEN] = ELEN'(i + 1);
            vs2[i*ELEN +: ELEN] = ELEN'(16 * i);
            exp[i*ELEN +: ELEN] = ELEN'(17 * i + 1);
        end
        vd = rand_vec();
        do_op(3'd0, 1'b0, 32'h0, VLW'(8), vs1, vs2, vd, lat, got, ill);
        check_cnt++; if (got !== exp) $display("FAIL add_vd got=%h exp=%h", got, exp); else pass_cnt++;
        check_cnt++; if (lat !== 4) $display("FAIL add_latency got=%0d exp=4", lat); else pass_cnt++;
        check_cnt++; if (ill !== 1'b0) $display("FAIL add_illegal got=%b exp=0", ill); else pass_cnt++;
        finish_rsp();
    endtask

    task automatic test_sub_vx();
        logic [W-1:0] vs2, exp, got;
        logic ill; int lat;
        for (int i = 0; i < VLMAX; i++) begin
            vs2[i*ELEN +: ELEN] = 32'd3;
            exp[i*ELEN +: ELEN] = 32'hFFFF_FFFE;
        end
        do_op(3'd1, 1'b1, 32'd5, VLW'(8), rand_vec(), vs2, rand_vec(), lat, got, ill);
        check_cnt++; if (got !== exp) $display("FAIL sub_vx_vd got=%h exp=%h", got, exp); else pass_cnt++;
        finish_rsp();
    endtask

    task automatic test_slides();
        logic [W-1:0] vs2, vd, exp_up, exp_dn, got;
        logic ill; int lat;
        for (int i = 0; i < VLMAX; i++) begin
            vs2[i*ELEN +: ELEN] = ELEN'(32'hA0 + i);
            vd[i*ELEN +: ELEN]  = 32'hEE;
            exp_up[i*ELEN +: ELEN] = (i == 0) ? 32'h77 : (i < 5) ? ELEN'(32'hA0 + i - 1) : 32'hEE;
            exp_dn[i*ELEN +: ELEN] = (i == VLMAX-1) ? 32'h0 : ELEN'(32'hA1 + i);
        end
        do_op(3'd2, 1'b0, 32'h77, VLW'(5), rand_vec(), vs2, vd, lat, got, ill);
        check_cnt++; if (got !== exp_up) $display("FAIL slide1up_vd got=%h exp=%h", got, exp_up); else pass_cnt++;
        finish_rsp();
        do_op(3'd3, 1'b0, 32'h0, VLW'(8), rand_vec(), vs2, vd, lat, got, ill);
        check_cnt++; if (got !== exp_dn) $display("FAIL slide1down_vd got=%h exp=%h", got, exp_dn); else pass_cnt++;
        finish_rsp();
    endtask

    task automatic test_macc();
        logic [W-1:0] vs1, vs2, vd, exp, got;
        logic ill, exp_ill; int lat, exp_lat;
        for (int i = 0; i < VLMAX; i++) begin
            vs1[i*ELEN +: ELEN] = 32'h7000;
            vs2[i*ELEN +: ELEN] = 32'h7000;
            vd[i*ELEN +: ELEN]  = 32'h1;
`ifdef VEXEC_MACC_EN
            exp[i*ELEN +: ELEN] = 32'h3100_0001;
`else
            exp[i*ELEN +: ELEN] = 32'h1;
`endif
        end
`ifdef VEXEC_MACC_EN
        exp_ill = 1'b0; exp_lat = 4;
`else
        exp_ill = 1'b1; exp_lat = 1;
`endif
        do_op(3'd4, 1'b0, 32'h0, VLW'(8), vs1, vs2, vd, lat, got, ill);
        check_cnt++; if (got !== exp) $display("FAIL macc_vd got=%h exp=%h", got, exp); else pass_cnt++;
        check_cnt++; if (ill !== exp_ill) $display("FAIL macc_illegal got=%b exp=%b", ill, exp_ill); else pass_cnt++;
        check_cnt++; if (lat !== exp_lat) $display("FAIL macc_latency got=%0d exp=%0d", lat, exp_lat); else pass_cnt++;
        finish_rsp();
    endtask

    task automatic test_short_path();
        logic [W-1:0] vd, got;
        logic ill; int lat;
        vd = rand_vec();
        do_op(3'd0, 1'b0, 32'h0, VLW'(0), rand_vec(), rand_vec(), vd, lat, got, ill);
        check_cnt++; if (got !== vd) $display("FAIL vl0_vd got=%h exp=%h", got, vd); else pass_cnt++;
        check_cnt++; if (lat !== 1) $display("FAIL vl0_latency got=%0d exp=1", lat); else pass_cnt++;
        check_cnt++; if (ill !== 1'b0) $display("FAIL vl0_illegal got=%b exp=0", ill); else pass_cnt++;
        finish_rsp();
        vd = rand_vec();
        do_op(3'd6, 1'b1, $urandom, VLW'(8), rand_vec(), rand_vec(), vd, lat, got, ill);
        check_cnt++; if (got !== vd) $display("FAIL illegal_vd got=%h exp=%h", got, vd); else pass_cnt++;
        check_cnt++; if (ill !== 1'b1) $display("FAIL illegal_flag got=%b exp=1", ill); else pass_cnt++;
        check_cnt++; if (lat !== 1) $display("FAIL illegal_latency got=%0d exp=1", lat); else pass_cnt++;
        finish_rsp();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] vs1, vs2, vd, exp, got;
        logic ill, exp_ill; int lat, exp_lat;
        vs1 = rand_vec(); vs2 = rand_vec(); vd = rand_vec();
        ref_model(3'd0, 1'b0, 32'h0, VLW'(6), vs1, vs2, vd, exp, exp_ill, exp_lat);
        do_op(3'd0, 1'b0, 32'h0, VLW'(6), vs1, vs2, vd, lat, got, ill);
        for (int c = 0; c < 10; c++) begin
            check_cnt++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_vd !== exp || bus.req_ready !== 1'b0)
                $display("FAIL backpressure_hold cyc=%0d valid=%b ready=%b vd=%h exp_vd=%h",
                         c, bus.rsp_valid, bus.req_ready, bus.rsp_vd, exp);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        finish_rsp();
        check_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL backpressure_release req_ready=%b exp=1", bus.req_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid_exec();
        bit saw_valid;
        bus.req_op = 3'd0; bus.req_use_scalar = 1'b0; bus.req_vl = VLW'(8);
        bus.req_vs1 = rand_vec(); bus.req_vs2 = rand_vec(); bus.req_vd = rand_vec();
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check_cnt++; if (busy !== 1'b1) $display("FAIL midexec_busy_before got=%b exp=1", busy); else pass_cnt++;
        resetn = 1'b0;
        @(posedge clk); #1;
        check_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL midexec_rsp_valid got=%b exp=0", bus.rsp_valid); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL midexec_busy got=%b exp=0", busy); else pass_cnt++;
        check_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL midexec_req_ready got=%b exp=1", bus.req_ready); else pass_cnt++;
        resetn = 1'b1;
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) saw_valid = 1'b1;
        end
        check_cnt++; if (saw_valid !== 1'b0) $display("FAIL midexec_no_response got=%b exp=0", saw_valid); else pass_cnt++;
        $display("reset mid-exec done");
    endtask

    task automatic test_random();
        logic [W-1:0] vs1, vs2, vd, exp, got;
        logic [2:0] op; logic us, ill, exp_ill;
        logic [ELEN-1:0] sc; logic [VLW-1:0] vl;
        int lat, exp_lat;
        for (int t = 0; t < 40; t++) begin
            op = 3'($urandom_range(0, 7)); us = 1'($urandom); sc = $urandom;
            vl = VLW'($urandom_range(0, 15));
            vs1 = rand_vec(); vs2 = rand_vec(); vd = rand_vec();
            ref_model(op, us, sc, vl, vs1, vs2, vd, exp, exp_ill, exp_lat);
            do_op(op, us, sc, vl, vs1, vs2, vd, lat, got, ill);
            check_cnt++;
            if (got !== exp || ill !== exp_ill || lat !== exp_lat)
                $display("FAIL random_%0d op=%0d vl=%0d vd=%h exp_vd=%h ill=%b exp_ill=%b lat=%0d exp_lat=%0d",
                         t, op, vl, got, exp, ill, exp_ill, lat, exp_lat);
            else pass_cnt++;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            finish_rsp();
        end
    endtask

    initial begin
        pass_cnt = 0; check_cnt = 0;
        resetn = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_use_scalar = 1'b0;
        bus.req_scalar = '0; bus.req_vl = '0;
        bus.req_vs1 = '0; bus.req_vs2 = '0; bus.req_vd = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub_vx();
        test_slides();
        test_macc();
        test_short_path();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
